// File: rtl/player_input_if.sv
// Button/lights signal bundle for player_input: raw active-low keys and CPU
// aggressiveness in, one-cycle press pulses out.
interface player_input_if;
  logic       key_l_n;
  logic       key_r_n;
  logic [8:0] cpu_speed;
  logic       L;
  logic       R;

  modport master (output key_l_n, key_r_n, cpu_speed, input L, R);
  modport slave  (input key_l_n, key_r_n, cpu_speed, output L, R);
endinterface

// File: rtl/player_input.sv
// Debounced player buttons producing one-cycle press pulses for the playfield.
// Define CPU_PLAYER_EN to drive R from an LFSR-based computer player instead of key_r_n.
module player_input #(
  parameter int DB_CYCLES = 4,
  parameter int CPU_TICK  = 1024
) (
  input  logic          Clock,
  input  logic          reset,
  player_input_if.slave io
);

  localparam int CW = $clog2(DB_CYCLES);

`ifdef CPU_PLAYER_EN
  localparam int NCH = 1;
`else
  localparam int NCH = 2;
`endif

  logic [NCH-1:0] raw_n;
  logic [NCH-1:0] pulse;

`ifdef CPU_PLAYER_EN
  logic unused_key_r;
  assign unused_key_r = io.key_r_n;
  assign raw_n        = io.key_l_n;
`else
  logic [8:0] unused_cpu_speed;
  assign unused_cpu_speed = io.cpu_speed;
  assign raw_n            = {io.key_r_n, io.key_l_n};
`endif

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic          sync1_q, sync1_d;
      logic          sync2_q, sync2_d;
      logic          stable_q, stable_d;
      logic          stable_prev_q, stable_prev_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // Any cycle agreeing with the accepted level restarts the hold count.
      always_comb begin
        sync1_d       = ~raw_n[gi];
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        cnt_d         = '0;
        if (sync2_q != stable_q) begin
          if (cnt_q == CW'(DB_CYCLES - 1)) begin
            stable_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge Clock) begin
        if (reset) begin
          sync1_q       <= 1'b0;
          sync2_q       <= 1'b0;
          stable_q      <= 1'b0;
          stable_prev_q <= 1'b0;
          cnt_q         <= '0;
        end else begin
          sync1_q       <= sync1_d;
          sync2_q       <= sync2_d;
          stable_q      <= stable_d;
          stable_prev_q <= stable_prev_d;
          cnt_q         <= cnt_d;
        end
      end

      assign pulse[gi] = stable_q & ~stable_prev_q;
    end
  endgenerate

  assign io.L = pulse[0] & ~reset;

`ifdef CPU_PLAYER_EN
  localparam int TW = (CPU_TICK > 1) ? $clog2(CPU_TICK) : 1;

  logic [9:0]    lfsr_q, lfsr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          cpu_press;

  // Fibonacci LFSR x^10 + x^7 + 1; the computer presses on the last tick of
  // each period when the random draw falls below its aggressiveness.
  always_comb begin
    lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    tick_d    = (tick_q == TW'(CPU_TICK - 1)) ? '0 : tick_q + 1'b1;
    cpu_press = (tick_q == TW'(CPU_TICK - 1)) && (lfsr_q < {1'b0, io.cpu_speed});
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      lfsr_q <= 10'h001;
      tick_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      tick_q <= tick_d;
    end
  end

  assign io.R = cpu_press & ~reset;
`else
  assign io.R = pulse[1] & ~reset;
`endif

endmodule

// File: tb/tb_player_input.sv
// Scoreboard bench for player_input: expected pulse cycles are queued when keys
// are driven and matched by a monitor sampling 1 time unit after each falling edge.
module tb_player_input;
  localparam int DB       = 4;
  localparam int LAT      = DB + 2;
  localparam int CPU_TICK = 8;

  logic Clock = 1'b0;
  logic reset = 1'b1;
  always #5 Clock = ~Clock;

  player_input_if io();

  player_input #(.DB_CYCLES(DB), .CPU_TICK(CPU_TICK)) dut (
    .Clock(Clock),
    .reset(reset),
    .io   (io)
  );

  int cyc    = 0;
  int checks = 0;
  int passed = 0;
  int exp_l[$];
  int exp_r[$];
  int mon_e;
  int r_count = 0;
  logic prev_r = 1'b0;
  logic exp_r_now;

  always @(posedge Clock) cyc <= cyc + 1;

`ifdef CPU_PLAYER_EN
  logic [9:0] m_lfsr = 10'h001;
  int         m_tick = 0;
  always @(posedge Clock) begin
    if (reset) begin
      m_lfsr <= 10'h001;
      m_tick <= 0;
    end else begin
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      m_tick <= (m_tick == CPU_TICK - 1) ? 0 : m_tick + 1;
    end
  end
`endif

  // Scoreboard comparator
  always @(negedge Clock) begin
    #1;
    if (io.L === 1'b1) begin
      checks++;
      if (exp_l.size() == 0) begin
        $display("FAIL L_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = exp_l.pop_front();
        if (mon_e !== cyc) $display("FAIL L_timing: pulse at cycle %0d, required cycle %0d", cyc, mon_e);
        else passed++;
      end
    end else if (exp_l.size() > 0 && exp_l[0] <= cyc) begin
      checks++;
      mon_e = exp_l.pop_front();
      $display("FAIL L_missing: L=%b at cycle %0d, required pulse at cycle %0d", io.L, cyc, mon_e);
    end

`ifdef CPU_PLAYER_EN
    exp_r_now = (reset === 1'b0) && (m_tick == CPU_TICK - 1) && (m_lfsr < {1'b0, io.cpu_speed});
    checks++;
    if (io.R !== exp_r_now) $display("FAIL R_cpu: R=%b at cycle %0d, required %b", io.R, cyc, exp_r_now);
    else passed++;
    if (io.R === 1'b1) begin
      r_count++;
      checks++;
      if (prev_r) $display("FAIL R_consecutive: R=1 at cycles %0d and %0d, required isolated", cyc - 1, cyc);
      else passed++;
    end
    prev_r = (io.R === 1'b1);
`else
    if (io.R === 1'b1) begin
      checks++;
      if (exp_r.size() == 0) begin
        $display("FAIL R_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = exp_r.pop_front();
        if (mon_e !== cyc) $display("FAIL R_timing: pulse at cycle %0d, required cycle %0d", cyc, mon_e);
        else passed++;
      end
    end else if (exp_r.size() > 0 && exp_r[0] <= cyc) begin
      checks++;
      mon_e = exp_r.pop_front();
      $display("FAIL R_missing: R=%b at cycle %0d, required pulse at cycle %0d", io.R, cyc, mon_e);
    end
`endif
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic test_reset();
    int r;
    io.key_l_n   = 1'b0;
    io.key_r_n   = 1'b1;
    io.cpu_speed = 9'd0;
    reset        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      #2;
      checks++;
      if (io.L !== 1'b0 || io.R !== 1'b0)
        $display("FAIL reset_out: L=%b R=%b during reset, required 0 0", io.L, io.R);
      else passed++;
    end
    step(1);
    reset = 1'b0;
    r = cyc;
    exp_l.push_back(r + LAT);
    $display("reset released at cycle %0d with key_l held, expect L at %0d", r, r + LAT);
    step(15);
    io.key_l_n = 1'b1;
    step(10);
    checks++;
    if (exp_l.size() != 0) $display("FAIL reset_hold_pending: %0d pulses outstanding, required 0", exp_l.size());
    else passed++;
  endtask

  task automatic test_press_hold();
    int d;
    d = cyc;
    io.key_l_n = 1'b0;
    exp_l.push_back(d + LAT);
    $display("press_hold: key_l low at cycle %0d for 20 cycles, expect L at %0d", d, d + LAT);
    step(20);
    io.key_l_n = 1'b1;
    step(10);
    checks++;
    if (exp_l.size() != 0 || exp_r.size() != 0)
      $display("FAIL press_hold_pending: %0d/%0d pulses outstanding, required 0/0", exp_l.size(), exp_r.size());
    else passed++;
  endtask

  task automatic test_short_glitch();
    int d;
    $display("glitch: key_l low for %0d cycles at cycle %0d, expect no pulse", DB - 1, cyc);
    io.key_l_n = 1'b0;
    step(DB - 1);
    io.key_l_n = 1'b1;
    step(6);
    d = cyc;
    io.key_l_n = 1'b0;
    exp_l.push_back(d + LAT);
    $display("glitch: key_l low for exactly %0d cycles at cycle %0d, expect L at %0d", DB, d, d + LAT);
    step(DB);
    io.key_l_n = 1'b1;
    step(10);
    checks++;
    if (exp_l.size() != 0) $display("FAIL glitch_pending: %0d pulses outstanding, required 0", exp_l.size());
    else passed++;
  endtask

`ifndef CPU_PLAYER_EN
  task automatic test_bounce();
    int d;
    for (int i = 0; i < 10; i++) begin
      io.key_r_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    d = cyc;
    io.key_r_n = 1'b0;
    exp_r.push_back(d + LAT);
    $display("bounce: key_r settled low at cycle %0d, expect R at %0d", d, d + LAT);
    step(10);
    io.key_r_n = 1'b1;
    step(10);
    checks++;
    if (exp_r.size() != 0) $display("FAIL bounce_pending: %0d pulses outstanding, required 0", exp_r.size());
    else passed++;
  endtask

  task automatic test_both();
    int d;
    d = cyc;
    io.key_l_n = 1'b0;
    io.key_r_n = 1'b0;
    exp_l.push_back(d + LAT);
    exp_r.push_back(d + LAT);
    $display("both: keys low at cycle %0d, expect L and R at %0d", d, d + LAT);
    step(10);
    io.key_l_n = 1'b1;
    io.key_r_n = 1'b1;
    step(10);
    checks++;
    if (exp_l.size() != 0 || exp_r.size() != 0)
      $display("FAIL both_pending: %0d/%0d pulses outstanding, required 0/0", exp_l.size(), exp_r.size());
    else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    int r;
    io.key_l_n = 1'b0;
    step(4);
    reset = 1'b1;
    #2;
    checks++;
    if (io.L !== 1'b0 || io.R !== 1'b0)
      $display("FAIL reset_mid_out: L=%b R=%b during reset, required 0 0", io.L, io.R);
    else passed++;
    step(1);
    reset = 1'b0;
    r = cyc;
    exp_l.push_back(r + LAT);
    $display("reset_mid: reset pulsed mid-debounce, released at cycle %0d, expect L at %0d", r, r + LAT);
    step(12);
    io.key_l_n = 1'b1;
    step(10);
    checks++;
    if (exp_l.size() != 0) $display("FAIL reset_mid_pending: %0d pulses outstanding, required 0", exp_l.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    int d, hold, gap, ch;
    for (int i = 0; i < 8; i++) begin
`ifdef CPU_PLAYER_EN
      ch = 0;
`else
      ch = $urandom_range(0, 1);
`endif
      hold = $urandom_range(DB, DB + 4);
      gap  = $urandom_range(DB + 1, DB + 5);
      d = cyc;
      if (ch == 0) begin
        io.key_l_n = 1'b0;
        exp_l.push_back(d + LAT);
      end else begin
        io.key_r_n = 1'b0;
        exp_r.push_back(d + LAT);
      end
      $display("back_to_back: ch=%0d press at cycle %0d hold=%0d gap=%0d, expect pulse at %0d",
               ch, d, hold, gap, d + LAT);
      step(hold);
      io.key_l_n = 1'b1;
      io.key_r_n = 1'b1;
      step(gap);
    end
    step(10);
    checks++;
    if (exp_l.size() != 0 || exp_r.size() != 0)
      $display("FAIL back_to_back_pending: %0d/%0d pulses outstanding, required 0/0", exp_l.size(), exp_r.size());
    else passed++;
  endtask

`ifdef CPU_PLAYER_EN
  task automatic test_cpu();
    io.cpu_speed = 9'd0;
    r_count = 0;
    $display("cpu: cpu_speed=0 for 200 cycles from cycle %0d, expect no R", cyc);
    step(200);
    checks++;
    if (r_count != 0) $display("FAIL cpu_zero: %0d R pulses, required 0", r_count);
    else passed++;
    io.cpu_speed = 9'h1FF;
    r_count = 0;
    $display("cpu: cpu_speed=1FF for 200 cycles from cycle %0d, expect R on ticks only", cyc);
    step(200);
    checks++;
    if (r_count == 0) $display("FAIL cpu_max: %0d R pulses, required at least 1", r_count);
    else passed++;
    io.cpu_speed = 9'd0;
    step(10);
  endtask
`endif

  initial begin
    io.key_l_n   = 1'b1;
    io.key_r_n   = 1'b1;
    io.cpu_speed = 9'd0;
    test_reset();
    test_press_hold();
    test_short_glitch();
`ifndef CPU_PLAYER_EN
    test_bounce();
    test_both();
`endif
    test_reset_mid();
    test_back_to_back();
`ifdef CPU_PLAYER_EN
    test_cpu();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
